// File: rtl/hand_pose_scheduler_pkg.sv
// Shared types and limits for the hand-pose source scheduler.
package hand_pkg;

  localparam int MAX_X         = 3400;
  localparam int MAX_Y         = 3400;
  localparam int MAX_Z         = 500;
  localparam int HAND_RESET_XY = 1800;
  localparam int XY_W          = 12;
  localparam int Z_W           = 14;

  typedef struct packed {
    logic [XY_W-1:0] x_bottom;
    logic [XY_W-1:0] y_bottom;
    logic [Z_W-1:0]  z_bottom;
    logic [XY_W-1:0] x_top;
    logic [XY_W-1:0] y_top;
    logic [Z_W-1:0]  z_top;
  } hand_pose_t;

  typedef enum logic [1:0] {WAIT_FRAME, LATCH, PRESENT} state_t;

  localparam hand_pose_t HAND_RESET_POSE = '{
    x_bottom: XY_W'(HAND_RESET_XY), y_bottom: XY_W'(HAND_RESET_XY), z_bottom: '0,
    x_top:    XY_W'(HAND_RESET_XY), y_top:    XY_W'(HAND_RESET_XY), z_top:    '0};

  // Saturate to lim-1 instead of wrapping.
  function automatic logic [XY_W-1:0] sat_xy(input logic [XY_W-1:0] v, input int lim);
    return (int'(v) > lim - 1) ? XY_W'(lim - 1) : v;
  endfunction

  function automatic logic [Z_W-1:0] sat_z(input logic [Z_W-1:0] v, input int lim);
    return (int'(v) > lim - 1) ? Z_W'(lim - 1) : v;
  endfunction

endpackage

// File: rtl/hand_pose_scheduler_if.sv
// Camera sample stream and pose snapshot stream between the scheduler and its neighbours.
interface hand_pose_if;
  logic        cam_valid_in;
  logic        cam_ready_out;
  logic [11:0] cam_x_bottom_in, cam_y_bottom_in, cam_x_top_in, cam_y_top_in;
  logic [13:0] cam_z_bottom_in, cam_z_top_in;

  logic        pose_valid_out;
  logic        pose_ready_in;
  logic [11:0] pose_x_bottom_out, pose_y_bottom_out, pose_x_top_out, pose_y_top_out;
  logic [13:0] pose_z_bottom_out, pose_z_top_out;
  logic        source_out;

  // Scheduler side.
  modport slave (
    input  cam_valid_in, cam_x_bottom_in, cam_y_bottom_in, cam_z_bottom_in,
           cam_x_top_in, cam_y_top_in, cam_z_top_in, pose_ready_in,
    output cam_ready_out, pose_valid_out, pose_x_bottom_out, pose_y_bottom_out,
           pose_z_bottom_out, pose_x_top_out, pose_y_top_out, pose_z_top_out, source_out
  );

  // Camera pipeline + renderer side.
  modport master (
    output cam_valid_in, cam_x_bottom_in, cam_y_bottom_in, cam_z_bottom_in,
           cam_x_top_in, cam_y_top_in, cam_z_top_in, pose_ready_in,
    input  cam_ready_out, pose_valid_out, pose_x_bottom_out, pose_y_bottom_out,
           pose_z_bottom_out, pose_x_top_out, pose_y_top_out, pose_z_top_out, source_out
  );
endinterface

// File: rtl/hand_pose_clamp.sv
// Combinational saturation of a pose into the legal coordinate box.
module hand_pose_clamp
  import hand_pkg::*;
(
  input  hand_pose_t i_pose,
  output hand_pose_t o_pose
);
  assign o_pose.x_bottom = sat_xy(i_pose.x_bottom, MAX_X);
  assign o_pose.y_bottom = sat_xy(i_pose.y_bottom, MAX_Y);
  assign o_pose.z_bottom = sat_z (i_pose.z_bottom, MAX_Z);
  assign o_pose.x_top    = sat_xy(i_pose.x_top,    MAX_X);
  assign o_pose.y_top    = sat_xy(i_pose.y_top,    MAX_Y);
  assign o_pose.z_top    = sat_z (i_pose.z_top,    MAX_Z);
endmodule

// File: rtl/hand_pose_scheduler.sv
// Per-frame choice between camera and button hand pose, snapshot held for the whole frame.
module hand_pose_scheduler
  import hand_pkg::*;
#(
  parameter int CAM_TIMEOUT = 4_000_000,
  parameter int MISS_W      = 8
) (
  input  logic              clk_in,
  input  logic              rst_in,
  hand_pose_if.slave        io,
  input  logic [11:0]       btn_x_bottom_in, btn_y_bottom_in, btn_x_top_in, btn_y_top_in,
  input  logic [13:0]       btn_z_bottom_in, btn_z_top_in,
  input  logic              force_btn_in,
  input  logic              frame_start_in,
  output logic              cam_stale_out,
  output logic [MISS_W-1:0] missed_frames_out
);
  localparam int               CNT_W   = $clog2(CAM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CAM_TIMEOUT);

  state_t            r_state, w_next;
  hand_pose_t        r_shadow, r_pose, w_cam_raw, w_cam_sat, w_btn;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_seen, r_src;
  logic [MISS_W-1:0] r_missed;
  logic              w_cam_ready, w_accept, w_stale, w_use_cam;

  assign w_cam_raw = '{x_bottom: io.cam_x_bottom_in, y_bottom: io.cam_y_bottom_in,
                       z_bottom: io.cam_z_bottom_in, x_top: io.cam_x_top_in,
                       y_top: io.cam_y_top_in, z_top: io.cam_z_top_in};
  // Buttons are already range-limited by hand_controller.
  assign w_btn     = '{x_bottom: btn_x_bottom_in, y_bottom: btn_y_bottom_in,
                       z_bottom: btn_z_bottom_in, x_top: btn_x_top_in,
                       y_top: btn_y_top_in, z_top: btn_z_top_in};

  hand_pose_clamp u_clamp (.i_pose(w_cam_raw), .o_pose(w_cam_sat));

  // Stall the camera only while the snapshot is being taken.
  assign w_cam_ready = (r_state != LATCH);
  assign w_accept    = io.cam_valid_in & w_cam_ready;
  assign w_stale     = !r_seen || (r_cnt == CNT_MAX);
  assign w_use_cam   = !force_btn_in && !w_stale;

  // Camera shadow registers and staleness timer.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_shadow <= HAND_RESET_POSE;
      r_cnt    <= '0;
      r_seen   <= 1'b0;
    end else if (w_accept) begin
      r_shadow <= w_cam_sat;
      r_cnt    <= '0;
      r_seen   <= 1'b1;
    end else if (r_cnt != CNT_MAX) begin
      r_cnt    <= r_cnt + 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) r_state <= WAIT_FRAME;
    else         r_state <= w_next;
  end

  // Next-state logic: one latch cycle, then hold the snapshot until the renderer takes it.
  always_comb begin
    w_next = r_state;
    case (r_state)
      WAIT_FRAME: if (frame_start_in)   w_next = LATCH;
      LATCH:                            w_next = PRESENT;
      PRESENT:    if (io.pose_ready_in) w_next = WAIT_FRAME;
      default:                          w_next = WAIT_FRAME;
    endcase
  end

  // Snapshot: the only place pose and source change.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_pose <= HAND_RESET_POSE;
      r_src  <= 1'b0;
    end else if (r_state == LATCH) begin
      r_pose <= w_use_cam ? r_shadow : w_btn;
      r_src  <= w_use_cam;
    end
  end

  // Frame pulses arriving while busy are dropped and counted.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)
      r_missed <= '0;
    else if (frame_start_in && (r_state != WAIT_FRAME) && (r_missed != '1))
      r_missed <= r_missed + 1'b1;
  end

  assign io.cam_ready_out     = w_cam_ready;
  assign io.pose_valid_out    = (r_state == PRESENT);
  assign io.pose_x_bottom_out = r_pose.x_bottom;
  assign io.pose_y_bottom_out = r_pose.y_bottom;
  assign io.pose_z_bottom_out = r_pose.z_bottom;
  assign io.pose_x_top_out    = r_pose.x_top;
  assign io.pose_y_top_out    = r_pose.y_top;
  assign io.pose_z_top_out    = r_pose.z_top;
  assign io.source_out        = r_src;
  assign cam_stale_out        = w_stale;
  assign missed_frames_out    = r_missed;
endmodule

// File: tb/tb_hand_pose_scheduler.sv
// Directed bench for hand_pose_scheduler with a scoreboard of expected snapshots.
module tb_hand_pose_scheduler;
  localparam int TMO = 16;

  typedef struct {
    int xb, yb, zb, xt, yt, zt, src;
  } exp_t;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [11:0] btn_xb, btn_yb, btn_xt, btn_yt;
  logic [13:0] btn_zb, btn_zt;
  logic        force_btn, frame_start, cam_stale;
  logic [7:0]  missed;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  hand_pose_if bus();

  hand_pose_scheduler #(.CAM_TIMEOUT(TMO), .MISS_W(8)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .io(bus.slave),
    .btn_x_bottom_in(btn_xb), .btn_y_bottom_in(btn_yb),
    .btn_x_top_in(btn_xt), .btn_y_top_in(btn_yt),
    .btn_z_bottom_in(btn_zb), .btn_z_top_in(btn_zt),
    .force_btn_in(force_btn), .frame_start_in(frame_start),
    .cam_stale_out(cam_stale), .missed_frames_out(missed)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_cam(input int xb, yb, zb, xt, yt, zt);
    bus.cam_x_bottom_in = 12'(xb); bus.cam_y_bottom_in = 12'(yb);
    bus.cam_z_bottom_in = 14'(zb); bus.cam_x_top_in    = 12'(xt);
    bus.cam_y_top_in    = 12'(yt); bus.cam_z_top_in    = 14'(zt);
  endtask

  task automatic cam_send(input int xb, yb, zb, xt, yt, zt);
    set_cam(xb, yb, zb, xt, yt, zt);
    bus.cam_valid_in = 1'b1;
    tick();
    bus.cam_valid_in = 1'b0;
  endtask

  task automatic push(input int xb, yb, zb, xt, yt, zt, src);
    exp_t e;
    e = '{xb, yb, zb, xt, yt, zt, src};
    sb.push_back(e);
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // Wait (bounded) for a snapshot, compare with the scoreboard head, then consume it.
  task automatic pop_check(input string tag);
    int   n;
    exp_t e;
    n = 0;
    while (!bus.pose_valid_out && n < 20) begin tick(); n++; end
    chk({tag, "_vld"}, bus.pose_valid_out, 1);
    chk({tag, "_sb"}, (sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_xb"},  bus.pose_x_bottom_out, e.xb);
      chk({tag, "_yb"},  bus.pose_y_bottom_out, e.yb);
      chk({tag, "_zb"},  bus.pose_z_bottom_out, e.zb);
      chk({tag, "_xt"},  bus.pose_x_top_out,    e.xt);
      chk({tag, "_yt"},  bus.pose_y_top_out,    e.yt);
      chk({tag, "_zt"},  bus.pose_z_top_out,    e.zt);
      chk({tag, "_src"}, bus.source_out,        e.src);
    end
    bus.pose_ready_in = 1'b1;
    tick();
    bus.pose_ready_in = 1'b0;
    chk({tag, "_done"}, bus.pose_valid_out, 0);
  endtask

  initial begin
    rst_in = 1'b0;
    bus.cam_valid_in = 1'b0; bus.pose_ready_in = 1'b0;
    set_cam(0, 0, 0, 0, 0, 0);
    btn_xb = 12'd100; btn_yb = 12'd200; btn_zb = 14'd50;
    btn_xt = 12'd300; btn_yt = 12'd400; btn_zt = 14'd60;
    force_btn = 1'b0; frame_start = 1'b0;

    // Reset values
    #12;
    chk("rst_xb", bus.pose_x_bottom_out, 1800);
    chk("rst_yt", bus.pose_y_top_out, 1800);
    chk("rst_zt", bus.pose_z_top_out, 0);
    chk("rst_vld", bus.pose_valid_out, 0);
    chk("rst_src", bus.source_out, 0);
    chk("rst_stale", cam_stale, 1);
    chk("rst_miss", missed, 0);
    chk("rst_crdy", bus.cam_ready_out, 1);
    rst_in = 1'b1;
    tick();

    // No camera yet: buttons, valid two cycles after the pulse
    push(100, 200, 50, 300, 400, 60, 0);
    frame();
    chk("t1_lat1", bus.pose_valid_out, 0);
    chk("t1_crdy_latch", bus.cam_ready_out, 0);
    tick();
    chk("t1_lat2", bus.pose_valid_out, 1);
    chk("t1_stale", cam_stale, 1);
    pop_check("t1");

    // Camera sample with out-of-range fields is saturated
    cam_send(4000, 100, 900, 3399, 3400, 500);
    chk("t2_stale", cam_stale, 0);
    push(3399, 100, 499, 3399, 3399, 499, 1);
    frame();
    pop_check("t2");

    // Timeout: stale exactly at count TMO, then buttons are latched
    cam_send(1000, 1100, 200, 2000, 2100, 300);
    for (int i = 0; i < TMO - 1; i++) tick();
    chk("t3_stale_15", cam_stale, 0);
    tick();
    chk("t3_stale_16", cam_stale, 1);
    push(100, 200, 50, 300, 400, 60, 0);
    frame();
    pop_check("t3");
    set_cam(500, 600, 100, 700, 800, 150);
    bus.cam_valid_in = 1'b1;
    chk("t3_stale_pre", cam_stale, 1);
    tick();
    bus.cam_valid_in = 1'b0;
    chk("t3_stale_clr", cam_stale, 0);

    // Renderer stalls: snapshot stable, dropped pulses counted, force ignored mid-frame
    push(500, 600, 100, 700, 800, 150, 1);
    frame();
    tick();
    for (int c = 0; c < 10; c++) begin
      frame_start = (c == 1 || c == 4 || c == 7);
      force_btn   = (c >= 3 && c < 6);
      tick();
      chk("t4_hold_xb", bus.pose_x_bottom_out, 500);
      chk("t4_hold_src", bus.source_out, 1);
    end
    frame_start = 1'b0; force_btn = 1'b0;
    chk("t4_missed", missed, 3);
    pop_check("t4");

    // Accept and frame_start in the same cycle: the new sample wins
    set_cam(1234, 50, 10, 3000, 4095, 9999);
    bus.cam_valid_in = 1'b1;
    frame_start = 1'b1;
    push(1234, 50, 10, 3000, 3399, 499, 1);
    tick();
    bus.cam_valid_in = 1'b0;
    frame_start = 1'b0;
    chk("t5_crdy_latch", bus.cam_ready_out, 0);
    pop_check("t5");

    // Asynchronous reset in the middle of PRESENT
    chk("t6_missed_pre", missed, 3);
    frame();
    tick();
    chk("t6_vld", bus.pose_valid_out, 1);
    #2 rst_in = 1'b0;
    #1;
    chk("t6_vld_rst", bus.pose_valid_out, 0);
    chk("t6_xb_rst", bus.pose_x_bottom_out, 1800);
    chk("t6_yb_rst", bus.pose_y_bottom_out, 1800);
    chk("t6_zb_rst", bus.pose_z_bottom_out, 0);
    chk("t6_src_rst", bus.source_out, 0);
    chk("t6_miss_rst", missed, 0);
    chk("t6_stale_rst", cam_stale, 1);
    #10 rst_in = 1'b1;
    tick();
    chk("t6_vld_after", bus.pose_valid_out, 0);

    chk("sb_left", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/hand_pose_scheduler.md
Name: hand_pose_scheduler

Overview:
Selects, once per rendered frame, which hand-pose source drives the ray-tracer: the camera tracker or the button-driven hand_controller. Camera samples arrive on a valid/ready stream and are clamped into the legal coordinate box. A pose snapshot is latched on each frame_start pulse and held stable for the whole frame. The snapshot is offered to the renderer on a valid/ready handshake. The block sits between hand_controller / camera pipeline and the scene/renderer.

Parameters:
CAM_TIMEOUT, 4_000_000, cycles without an accepted camera sample before the camera is declared stale.
MISS_W, 8, width of the saturating missed-frame counter.

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous, active-low reset
cam_valid_in  input  1  camera sample valid
cam_ready_out  output  1  camera sample accepted when valid&ready
cam_x_bottom_in, cam_y_bottom_in, cam_x_top_in, cam_y_top_in  input  12 each  camera coordinates, unsigned
cam_z_bottom_in, cam_z_top_in  input  14 each  camera depth, unsigned
btn_x_bottom_in, btn_y_bottom_in, btn_x_top_in, btn_y_top_in  input  12 each  coordinates from hand_controller
btn_z_bottom_in, btn_z_top_in  input  14 each  depth from hand_controller
force_btn_in  input  1  switch; forces the button source
frame_start_in  input  1  one-cycle pulse from the renderer
pose_valid_out  output  1  snapshot available
pose_ready_in  input  1  renderer consumes the snapshot
pose_x_bottom_out, pose_y_bottom_out, pose_x_top_out, pose_y_top_out  output  12 each  snapshot coordinates
pose_z_bottom_out, pose_z_top_out  output  14 each  snapshot depth
source_out  output  1  0 = buttons, 1 = camera (source of the current snapshot)
cam_stale_out  output  1  camera timed out or never seen
missed_frames_out  output  MISS_W  saturating count of dropped frame_start pulses

Behaviour:
- Reset (rst_in low, async):
  - pose x/y outputs = 1800; pose z outputs = 0
  - pose_valid_out = 0, source_out = 0, cam_stale_out = 1, missed_frames_out = 0
  - shadow regs = 1800/1800/0; timeout counter = 0; state = WAIT_FRAME
- Camera intake:
  - cam_ready_out = 1 in every state except LATCH.
  - On accept, each field is saturated (not wrapped) and written to shadow regs:
    - x, y: values > MAX_X-1 / MAX_Y-1 become 3399
    - z: values > MAX_Z-1 become 499
  - Accept clears the timeout counter to 0 and clears cam_stale_out on the next edge.
- Timeout:
  - Counter increments every cycle without an accept and saturates at CAM_TIMEOUT.
  - cam_stale_out = 1 when the counter equals CAM_TIMEOUT, or when no accept has occurred since reset.
- Source select, evaluated in LATCH:
  - cam = !force_btn_in && !cam_stale_out
  - Button inputs are sampled directly. They need no clamping because hand_controller keeps them in range.
- FSM:
  - WAIT_FRAME: on frame_start_in -> LATCH.
  - LATCH (exactly 1 cycle): copy the selected source into the pose regs and set source_out -> PRESENT.
  - PRESENT: pose_valid_out = 1, held until the cycle pose_ready_in = 1. In that cycle the handshake completes and the next state is WAIT_FRAME, with pose_valid_out = 0 at the following edge.
- Stability: pose outputs and source_out change only on the LATCH edge.
- Latency:
  - frame_start in cycle N -> pose regs updated at edge N+1 -> pose_valid_out high from cycle N+2.
  - If pose_ready_in is already high, the handshake completes in cycle N+2.
- Simultaneous camera accept and frame_start in WAIT_FRAME: LATCH uses the newly accepted sample.
- frame_start_in while in LATCH or PRESENT: the pulse is dropped and missed_frames_out increments, saturating at 2^MISS_W-1. No queueing.
- force_btn_in toggled mid-frame: has no effect until the next LATCH.
- Reset asserted mid-operation: immediate return to the reset values above. No partial snapshot survives.

Decomposition:
- Package hand_pkg:
  - MAX_X = 3400, MAX_Y = 3400, MAX_Z = 500, HAND_RESET_XY = 1800
  - hand_pose_t: packed struct of x/y/z for bottom and top, 12/12/14 bits
  - state enum {WAIT_FRAME, LATCH, PRESENT}
- Sub-module hand_pose_clamp: purely combinational saturation of a hand_pose_t against the package maxima. It is reusable by the camera pipeline.

Test Plan:
- Reset release, no camera samples, frame_start pulse:
  - pose = buttons (e.g. 1800/1800/0), source_out = 0, cam_stale_out = 1
  - pose_valid_out rises 2 cycles after the pulse
- Camera sends x = 4000, y = 100, z = 900, then frame_start:
  - pose = 3399/100/499, source_out = 1, cam_stale_out = 0
- After a camera accept, hold cam_valid_in low for CAM_TIMEOUT cycles (bench param 16):
  - cam_stale_out rises exactly at count 16
  - next frame latches the buttons with source_out = 0
  - one new accept clears stale on the next edge
- pose_ready_in held low for 10 cycles, 3 frame_start pulses during PRESENT, force_btn_in toggled meanwhile:
  - pose stays constant, missed_frames_out = 3
  - handshake completes when ready rises
- cam_valid_in and frame_start_in in the same WAIT_FRAME cycle with x = 1234:
  - snapshot x = 1234
  - cam_ready_out = 0 during the LATCH cycle
- Assert rst_in low mid-PRESENT:
  - pose_valid_out = 0 and pose = 1800/1800/0 asynchronously
  - missed_frames_out = 0
